// File: rtl/sasanqua_ctrl_pkg.sv
// sasanqua_ctrl_pkg: response codes and word-index decode shared by the Sasanqua AXI-Lite register file.
package sasanqua_ctrl_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int ADDR_LSB = 2;

    typedef enum logic [1:0] {TGT_ID, TGT_CTRL, TGT_STAT, TGT_NONE} tgt_e;

    typedef struct packed {
        tgt_e       tgt;
        logic [3:0] idx;
    } dec_t;

    function automatic dec_t decode(input int unsigned word, input int unsigned num_ctrl, input int unsigned num_stat);
        dec_t d;
        d.tgt = word == 0 ? TGT_ID : word <= num_ctrl ? TGT_CTRL : word <= num_ctrl + num_stat ? TGT_STAT : TGT_NONE;
        d.idx = d.tgt == TGT_CTRL ? 4'(word - 1) : d.tgt == TGT_STAT ? 4'(word - num_ctrl - 1) : 4'd0;
        return d;
    endfunction
endpackage

// File: rtl/sasanqua_axil_hold.sv
// sasanqua_axil_hold: one-entry holding register for an AXI-Lite request channel.
module sasanqua_axil_hold #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [W-1:0] din,
    input  logic         block,
    input  logic         clear,
    output logic         ready,
    output logic         full,
    output logic [W-1:0] q
);
    assign ready = !full && !block;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            q    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (valid && ready) begin
            full <= 1'b1;
            q    <= din;
        end
    end
endmodule

// File: rtl/sasanqua_controller_axi_regs.sv
// sasanqua_controller_axi_regs: AXI4-Lite register file with ID word, RW control regs and RO status words.
module sasanqua_controller_axi_regs
    import sasanqua_ctrl_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 16,
    parameter int          NUM_CTRL = 4,
    parameter int          NUM_STAT = 4,
    parameter logic [31:0] ID_VALUE = 32'h5A5A0001
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [DATA_W-1:0]            S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]          S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [DATA_W-1:0]            S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    output logic [NUM_CTRL*DATA_W-1:0]   CTRL,
    output logic [NUM_CTRL-1:0]          CTRL_WE,
    input  logic [NUM_STAT*DATA_W-1:0]   STAT,
    output logic [NUM_STAT-1:0]          STAT_RE
);
    localparam int STRB_W = DATA_W / 8;

    if (DATA_W != 32) begin : g_bad_data_w
        $error("sasanqua_controller_axi_regs: DATA_W must be 32");
    end
    if (NUM_CTRL < 1 || NUM_CTRL > 16 || NUM_STAT < 1 || NUM_STAT > 16) begin : g_bad_count
        $error("sasanqua_controller_axi_regs: NUM_CTRL/NUM_STAT must be 1..16");
    end

    logic                     live, aw_full, w_full, commit, ar_pend, unused_lsb;
    logic [ADDR_W-1:0]        aw_q, ar_q;
    logic [DATA_W+STRB_W-1:0] w_q;
    logic [DATA_W-1:0]        wdata, ctrl_rd, stat_rd;
    logic [DATA_W-1:0]        ctrl_r [NUM_CTRL];
    logic [STRB_W-1:0]        wstrb;
    logic [NUM_STAT-1:0]      stat_hit;
    dec_t                     wdec, rdec;

    // live keeps every READY low while in reset and for the first cycle after it
    sasanqua_axil_hold #(.W(ADDR_W)) u_aw (
        .clk(CLK), .rst(RST), .valid(S_AXI_AWVALID), .din(S_AXI_AWADDR),
        .block(S_AXI_BVALID || !live), .clear(commit),
        .ready(S_AXI_AWREADY), .full(aw_full), .q(aw_q)
    );
    sasanqua_axil_hold #(.W(DATA_W + STRB_W)) u_w (
        .clk(CLK), .rst(RST), .valid(S_AXI_WVALID), .din({S_AXI_WSTRB, S_AXI_WDATA}),
        .block(S_AXI_BVALID || !live), .clear(commit),
        .ready(S_AXI_WREADY), .full(w_full), .q(w_q)
    );

    assign {wstrb, wdata}  = w_q;
    assign commit          = aw_full && w_full && !S_AXI_BVALID;
    assign wdec            = decode(32'(aw_q[ADDR_W-1:ADDR_LSB]), NUM_CTRL, NUM_STAT);
    assign rdec            = decode(32'(ar_q[ADDR_W-1:ADDR_LSB]), NUM_CTRL, NUM_STAT);
    assign S_AXI_ARREADY   = live && !S_AXI_RVALID && !ar_pend;
    assign unused_lsb      = ^{aw_q[ADDR_LSB-1:0], ar_q[ADDR_LSB-1:0]};

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
        assign CTRL[g*DATA_W +: DATA_W] = ctrl_r[g];
    end

    always_comb begin
        ctrl_rd  = '0;
        stat_rd  = '0;
        stat_hit = '0;
        for (int k = 0; k < NUM_CTRL; k++)
            if (rdec.idx == 4'(k)) ctrl_rd = ctrl_r[k];
        for (int k = 0; k < NUM_STAT; k++)
            if (rdec.idx == 4'(k)) begin
                stat_rd     = STAT[k*DATA_W +: DATA_W];
                stat_hit[k] = rdec.tgt == TGT_STAT;
            end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            live         <= 1'b0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            CTRL_WE      <= '0;
            for (int k = 0; k < NUM_CTRL; k++) ctrl_r[k] <= '0;
        end else begin
            live    <= 1'b1;
            CTRL_WE <= '0;
            if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            if (commit) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wdec.tgt == TGT_CTRL ? RESP_OKAY : RESP_SLVERR;
                for (int k = 0; k < NUM_CTRL; k++)
                    if (wdec.tgt == TGT_CTRL && wdec.idx == 4'(k)) begin
                        CTRL_WE[k] <= |wstrb;
                        for (int b = 0; b < STRB_W; b++)
                            if (wstrb[b]) ctrl_r[k][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ar_pend      <= 1'b0;
            ar_q         <= '0;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RRESP  <= RESP_OKAY;
            S_AXI_RDATA  <= '0;
            STAT_RE      <= '0;
        end else begin
            STAT_RE <= '0;
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                ar_pend <= 1'b1;
                ar_q    <= S_AXI_ARADDR;
            end
            if (S_AXI_RVALID && S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
            if (ar_pend) begin
                ar_pend      <= 1'b0;
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rdec.tgt == TGT_ID ? ID_VALUE : rdec.tgt == TGT_CTRL ? ctrl_rd :
                                rdec.tgt == TGT_STAT ? stat_rd : '0;
                S_AXI_RRESP  <= rdec.tgt == TGT_NONE ? RESP_SLVERR : RESP_OKAY;
                STAT_RE      <= stat_hit;
            end
        end
    end
endmodule

// File: tb/tb_sasanqua_controller_axi_regs.sv
// tb_sasanqua_controller_axi_regs: directed and randomized AXI-Lite traffic against a word-level register model.
module tb_sasanqua_controller_axi_regs;
    localparam int NC = 4;
    localparam int NS = 4;
    localparam logic [31:0] IDV = 32'h5A5A0001;

    logic           CLK = 1'b0, RST = 1'b1;
    logic [15:0]    S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic           S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0, S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
    logic [31:0]    S_AXI_WDATA = '0;
    logic [3:0]     S_AXI_WSTRB = '0;
    logic           S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]     S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0]    S_AXI_RDATA;
    logic [NC*32-1:0] CTRL;
    logic [NC-1:0]  CTRL_WE;
    logic [NS*32-1:0] STAT = '0;
    logic [NS-1:0]  STAT_RE;

    sasanqua_controller_axi_regs dut (
        .CLK(CLK), .RST(RST),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .CTRL(CTRL), .CTRL_WE(CTRL_WE), .STAT(STAT), .STAT_RE(STAT_RE)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    logic [31:0] m_ctrl [NC];
    int m_we [NC];
    int we_cnt [NC];
    int re_cnt [NS];

    initial for (int k = 0; k < NC; k++) begin m_ctrl[k] = '0; m_we[k] = 0; we_cnt[k] = 0; end
    initial for (int k = 0; k < NS; k++) re_cnt[k] = 0;

    always @(negedge CLK) begin
        for (int k = 0; k < NC; k++) if (CTRL_WE[k] === 1'b1) we_cnt[k]++;
        for (int k = 0; k < NS; k++) if (STAT_RE[k] === 1'b1) re_cnt[k]++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        for (int k = 0; k < NC; k++) begin
            chk($sformatf("ctrl%0d", k), CTRL[k*32 +: 32], m_ctrl[k]);
            chk($sformatf("we_count%0d", k), we_cnt[k], m_we[k]);
        end
    endtask

    // aw_st/w_st: cycle offsets at which AWVALID/WVALID rise; bdly < 0 leaves the response unacknowledged
    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aw_st, input int w_st, input int bdly);
        bit ad = 0, wd = 0, ha, hw;
        int lat = 1;
        int w = int'(a >> 2);
        bit is_ctrl = (w >= 1 && w <= NC);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        for (int c = 0; c < 40 && !(ad && wd); c++) begin
            @(negedge CLK);
            S_AXI_AWVALID = !ad && c >= aw_st;
            S_AXI_WVALID  = !wd && c >= w_st;
            ha = S_AXI_AWVALID && S_AXI_AWREADY;
            hw = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge CLK);
            ad |= ha; wd |= hw;
        end
        chk("wr_handshake", {ad, wd}, 2'b11);
        while (lat < 20) begin
            @(negedge CLK);
            S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
            if (S_AXI_BVALID) break;
            @(posedge CLK);
            lat++;
        end
        chk("wr_latency", lat, 2);
        chk("bresp", S_AXI_BRESP, is_ctrl ? 2'b00 : 2'b10);
        if (is_ctrl) begin
            for (int b = 0; b < 4; b++) if (s[b]) m_ctrl[w-1][b*8 +: 8] = d[b*8 +: 8];
            if (s != 0) m_we[w-1]++;
        end
        if (bdly < 0) return;
        for (int i = 0; i < bdly; i++) begin
            @(posedge CLK); @(negedge CLK);
            chk("bvalid_hold", {S_AXI_BVALID, S_AXI_AWREADY}, 2'b10);
        end
        S_AXI_BREADY = 1;
        @(posedge CLK); @(negedge CLK);
        S_AXI_BREADY = 0;
        chk("bvalid_clear", S_AXI_BVALID, 0);
        chk("awready_after_b", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        check_state();
    endtask

    task automatic rd(input logic [15:0] a, input int rdly);
        bit ad = 0, h;
        int lat = 1;
        int w = int'(a >> 2);
        logic [31:0] ed = 32'h0;
        logic [1:0] er = 2'b00;
        int re0 [NS];
        int sk = -1;
        if (w == 0) ed = IDV;
        else if (w <= NC) ed = m_ctrl[w-1];
        else if (w <= NC + NS) begin sk = w - NC - 1; ed = STAT[sk*32 +: 32]; end
        else er = 2'b10;
        re0 = re_cnt;
        S_AXI_ARADDR = a;
        for (int c = 0; c < 40 && !ad; c++) begin
            @(negedge CLK);
            S_AXI_ARVALID = 1;
            h = S_AXI_ARREADY;
            @(posedge CLK);
            ad |= h;
        end
        chk("ar_handshake", ad, 1);
        while (lat < 20) begin
            @(negedge CLK);
            S_AXI_ARVALID = 0;
            if (S_AXI_RVALID) break;
            @(posedge CLK);
            lat++;
        end
        chk("rd_latency", lat, 2);
        chk("rdata", S_AXI_RDATA, ed);
        chk("rresp", S_AXI_RRESP, er);
        chk("arready_busy", S_AXI_ARREADY, 0);
        for (int i = 0; i < rdly; i++) begin
            @(posedge CLK); @(negedge CLK);
            chk("rhold", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, ed});
        end
        S_AXI_RREADY = 1;
        @(posedge CLK); @(negedge CLK);
        S_AXI_RREADY = 0;
        chk("rvalid_clear", S_AXI_RVALID, 0);
        chk("arready_after_r", S_AXI_ARREADY, 1);
        for (int k = 0; k < NS; k++) chk($sformatf("stat_re%0d", k), re_cnt[k] - re0[k], (k == sk) ? 1 : 0);
    endtask

    task automatic reset_outs(input string tag);
        chk({tag, "_ready_valid"}, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}, 0);
        chk({tag, "_resp_data"}, {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 0);
        chk({tag, "_ctrl"}, {|CTRL, CTRL_WE, STAT_RE}, 0);
    endtask

    initial begin
        bit ad;
        bit h;
        for (int k = 0; k < NS; k++) STAT[k*32 +: 32] = $urandom;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        reset_outs("reset");
        RST = 0;

        rd(16'h0000, 0);
        wr(16'h0004, 32'h12345678, 4'hF, 0, 1, 0);
        wr(16'h0004, 32'h0BADF00D, 4'hF, 1, 0, 0);
        wr(16'h0004, 32'h12345678, 4'hF, 0, 0, 0);
        wr(16'h0004, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        chk("strobe_merge", CTRL[31:0], 32'h12BB56DD);
        wr(16'h0004, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
        wr(16'h0000, 32'h11111111, 4'hF, 0, 0, 0);
        wr(16'((NC + 1) * 4), 32'h22222222, 4'hF, 1, 0, 1);
        wr(16'h0100, 32'h33333333, 4'hF, 0, 2, 0);
        rd(16'h0100, 0);
        STAT[32 +: 32] = 32'hCAFEF00D;
        rd(16'((NC + 2) * 4), 5);

        repeat (60) begin
            logic [15:0] a = 16'($urandom_range(0, NC + NS + 3) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) STAT[$urandom_range(0, NS - 1)*32 +: 32] = $urandom;
            if ($urandom_range(0, 1) == 0)
                wr(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));
            else
                rd(a, $urandom_range(0, 3));
        end

        wr(16'h0008, 32'h87654321, 4'hF, 0, 0, -1);
        @(negedge CLK);
        chk("b_pending", S_AXI_BVALID, 1);
        RST = 1;
        @(posedge CLK); @(negedge CLK);
        reset_outs("rst_b_pending");
        RST = 0;
        for (int k = 0; k < NC; k++) m_ctrl[k] = '0;

        ad = 0;
        S_AXI_AWADDR = 16'h0008;
        for (int c = 0; c < 10 && !ad; c++) begin
            @(negedge CLK);
            S_AXI_AWVALID = 1;
            h = S_AXI_AWREADY;
            @(posedge CLK);
            ad |= h;
        end
        chk("aw_only_handshake", ad, 1);
        @(negedge CLK);
        S_AXI_AWVALID = 0;
        RST = 1;
        @(posedge CLK); @(negedge CLK);
        reset_outs("rst_aw_full");
        RST = 0;
        wr(16'h000C, 32'hDEADBEEF, 4'hF, 0, 1, 0);
        rd(16'h0008, 0);
        rd(16'h000C, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
